arith_rs_scheduler: RTL and testbench
=====================================

# arith_rs_scheduler

Reservation station and issue scheduler for the single-cycle arithmetic functional unit in the out-of-order engine. It accepts dispatched arithmetic micro-ops, holds each one until both source operands are available, and captures operands from the common data bus (CDB). Each cycle it issues the oldest ready entry to the arithmetic FU. Entries are kept in a collapsing queue, so age order is positional.

## Interface
Parameters:
- XLEN, 32, operand width
- ROB_SIZE, 256, ROB depth; tag width is TW = $clog2(ROB_SIZE)
- RS_ENTRIES, 4, queue depth (≥2)

Ports:
- clk  in  1  single clock
- rst  in  1  reset, synchronous, active-high
- flush  in  1  discard all held entries
- disp_valid  in  1  dispatch request
- disp_ready  out  1  queue can accept a dispatch
- disp_rob_entry  in  TW  ROB tag of the dispatched op
- disp_type  in  3  arithmetic_type: 000 add/sub, 010 slt, 011 sltu
- disp_additional_info  in  1  subtract select
- disp_rsN_rdy  in  1  operand N (N=1,2) value valid
- disp_rsN_val  in  XLEN  operand N value
- disp_rsN_tag  in  TW  producer ROB tag when not ready
- cdb_valid  in  1  CDB broadcast valid
- cdb_rob_entry  in  TW  broadcast tag
- cdb_value  in  XLEN  broadcast value
- issue_valid  out  1  issue to FU this cycle (FU drives valid_in from it)
- issue_type  out  3  to FU arithmetic_type
- issue_additional_info  out  1  to FU
- issue_rob_entry  out  TW  to FU rob_entry_in
- issue_rs1, issue_rs2  out  XLEN  to FU operands
- occupancy  out  $clog2(RS_ENTRIES+1)  valid entry count

## Operation
- Entry fields: valid, type, add_info, rob tag, and per operand {rdy, val, tag}. Entry 0 is the oldest.
- Dispatch fires when disp_valid && disp_ready. disp_ready = !rst && (count < RS_ENTRIES). Same-cycle issue does not relieve a full queue.
- Wakeup: on cdb_valid, every valid entry operand with !rdy and tag == cdb_rob_entry sets rdy=1 and val=cdb_value. This applies to entries that are shifting in the same cycle.
- Select: the lowest-index valid entry with both rdy bits set is chosen, using registered state only.
- Issue: the selected entry's fields are registered onto issue_* with issue_valid=1. The entry is removed and all higher entries shift down by one. The FU always accepts, so there is no backpressure.
- A dispatch in the same cycle as an issue is written at index count-1; otherwise it is written at index count.
- flush: all entries are invalidated and issue_valid goes to 0 next cycle. Flush has priority over dispatch, issue and wakeup.
- rst: same effect as flush, plus all issue_* outputs are cleared. Reset mid-operation drops everything and does not complete partial issues.
- Unsupported disp_type values are held and issued unchanged (the FU produces its default result).

## Timing
- Reset values: issue_valid 0, issue_type 0, issue_additional_info 0, issue_rob_entry 0, issue_rs1 0, issue_rs2 0, occupancy 0, disp_ready 0 while rst is high.
- Dispatch with both operands ready at edge E: the entry is held after E, is selected during E→E+1, and issue_valid is high in the cycle after edge E+1.
- A CDB wakeup at edge E makes the entry eligible for selection in the cycle after E, so issue follows after E+1.
- Throughput: at most one issue and one dispatch per cycle.
- Full: disp_ready is 0 when count == RS_ENTRIES and rises the cycle after an issue brings count below RS_ENTRIES.
- Empty: issue_valid is 0 and the issue_* data hold their last value.

## Configuration
- ARITH_RS_CDB_BYPASS_EN defined: if cdb_valid and the tag matches a not-ready disp_rsN_tag in the dispatch cycle, that operand is written with rdy=1 and val=cdb_value.
- Not defined: disp_ready is additionally forced to 0 in any cycle with cdb_valid=1, so a dispatch can never miss a broadcast.

## Test plan
- Dispatch tag 5, type 000, info 1, rs1=10, rs2=3, both ready, into an empty queue → issue_valid exactly one cycle later than the next edge, issue_rob_entry=5, issue_rs1=10, issue_rs2=3; occupancy returns to 0.
- Dispatch tag 7 with rs2 waiting on tag 9, then tag 8 fully ready → tag 8 issues first. CDB tag 9 value 0x20 → tag 7 issues the following cycle with issue_rs2=0x20.
- Fill 4 unready entries → disp_ready=0 and occupancy=4. Wake entry 2 → it issues, disp_ready=1 the next cycle, and entries 3→2 keep order.
- Dispatch with cdb_valid and a matching tag in the same cycle: with the macro defined the operand is captured and issues; without it, disp_ready=0 in that cycle and the dispatch is retried.
- flush with 3 entries held and an issue pending → next cycle issue_valid=0 and occupancy=0. A simultaneous dispatch is dropped.
- rst asserted mid-stream → all outputs 0 the next cycle and disp_ready=0 while rst is high.

Source files
------------

// File: rtl/arith_rs_if.sv
// Dispatch, CDB and issue bundle between the dispatch stage, the arithmetic
// reservation station (slave) and the functional unit it feeds.
interface arith_rs_if #(
   parameter int XLEN       = 32,
   parameter int ROB_SIZE   = 256,
   parameter int RS_ENTRIES = 4
);
   localparam int TW = $clog2(ROB_SIZE);
   localparam int CW = $clog2(RS_ENTRIES + 1);

   logic            flush;
   logic            disp_valid;
   logic            disp_ready;
   logic [TW-1:0]   disp_rob_entry;
   logic [2:0]      disp_type;
   logic            disp_additional_info;
   logic            disp_rs1_rdy;
   logic [XLEN-1:0] disp_rs1_val;
   logic [TW-1:0]   disp_rs1_tag;
   logic            disp_rs2_rdy;
   logic [XLEN-1:0] disp_rs2_val;
   logic [TW-1:0]   disp_rs2_tag;
   logic            cdb_valid;
   logic [TW-1:0]   cdb_rob_entry;
   logic [XLEN-1:0] cdb_value;
   logic            issue_valid;
   logic [2:0]      issue_type;
   logic            issue_additional_info;
   logic [TW-1:0]   issue_rob_entry;
   logic [XLEN-1:0] issue_rs1;
   logic [XLEN-1:0] issue_rs2;
   logic [CW-1:0]   occupancy;

   modport master (
      output flush, disp_valid, disp_rob_entry, disp_type, disp_additional_info,
             disp_rs1_rdy, disp_rs1_val, disp_rs1_tag,
             disp_rs2_rdy, disp_rs2_val, disp_rs2_tag,
             cdb_valid, cdb_rob_entry, cdb_value,
      input  disp_ready, issue_valid, issue_type, issue_additional_info,
             issue_rob_entry, issue_rs1, issue_rs2, occupancy
   );

   modport slave (
      input  flush, disp_valid, disp_rob_entry, disp_type, disp_additional_info,
             disp_rs1_rdy, disp_rs1_val, disp_rs1_tag,
             disp_rs2_rdy, disp_rs2_val, disp_rs2_tag,
             cdb_valid, cdb_rob_entry, cdb_value,
      output disp_ready, issue_valid, issue_type, issue_additional_info,
             issue_rob_entry, issue_rs1, issue_rs2, occupancy
   );
endinterface

// File: rtl/arith_rs_scheduler.sv
// Collapsing-queue reservation station for the arithmetic FU: issues the oldest ready entry, 1 cycle after it becomes ready.
// No issue backpressure; disp_ready drops when full. ARITH_RS_CDB_BYPASS_EN lets a dispatch capture a same-cycle CDB broadcast.
module arith_rs_scheduler #(
   parameter int XLEN       = 32,
   parameter int ROB_SIZE   = 256,
   parameter int RS_ENTRIES = 4
) (
   input  logic       clk,
   input  logic       rst,
   arith_rs_if.slave  rs_if
);
   localparam int TW = $clog2(ROB_SIZE);
   localparam int CW = $clog2(RS_ENTRIES + 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(RS_ENTRIES);

   typedef struct packed {
      logic            valid;
      logic [2:0]      typ;
      logic            info;
      logic [TW-1:0]   rob;
      logic            rs1_rdy;
      logic [XLEN-1:0] rs1_val;
      logic [TW-1:0]   rs1_tag;
      logic            rs2_rdy;
      logic [XLEN-1:0] rs2_val;
      logic [TW-1:0]   rs2_tag;
   } ent_t;

   ent_t            ent_q [RS_ENTRIES];
   ent_t            ent_d [RS_ENTRIES];
   ent_t            woke  [RS_ENTRIES+1];
   ent_t            sel_ent;
   ent_t            new_ent;
   logic [CW-1:0]   count_q, count_d;
   logic [CW-1:0]   sel_idx, wr_idx;
   logic            sel_found;
   logic            disp_ready;
   logic            disp_fire;

   logic            issue_valid_q, issue_valid_d;
   logic [2:0]      issue_type_q, issue_type_d;
   logic            issue_info_q, issue_info_d;
   logic [TW-1:0]   issue_rob_q, issue_rob_d;
   logic [XLEN-1:0] issue_rs1_q, issue_rs1_d;
   logic [XLEN-1:0] issue_rs2_q, issue_rs2_d;

   function automatic ent_t wake(input ent_t e, input logic v,
                                 input logic [TW-1:0] tag, input logic [XLEN-1:0] val);
      ent_t r;
      r = e;
      if (v && e.valid && !e.rs1_rdy && e.rs1_tag == tag) begin
         r.rs1_rdy = 1'b1;
         r.rs1_val = val;
      end
      if (v && e.valid && !e.rs2_rdy && e.rs2_tag == tag) begin
         r.rs2_rdy = 1'b1;
         r.rs2_val = val;
      end
      return r;
   endfunction

`ifdef ARITH_RS_CDB_BYPASS_EN
   assign disp_ready = !rst && (count_q < FULL_CNT);
`else
   // Without the bypass a dispatch could miss a broadcast aimed at its own sources.
   assign disp_ready = !rst && (count_q < FULL_CNT) && !rs_if.cdb_valid;
`endif
   assign disp_fire = rs_if.disp_valid && disp_ready;

   // Oldest-first select, from registered state only.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      sel_ent   = '0;
      for (int i = 0; i < RS_ENTRIES; i++) begin
         if (!sel_found && ent_q[i].valid && ent_q[i].rs1_rdy && ent_q[i].rs2_rdy) begin
            sel_found = 1'b1;
            sel_idx   = CW'(i);
            sel_ent   = ent_q[i];
         end
      end
   end

   always_comb begin
      new_ent         = '0;
      new_ent.valid   = 1'b1;
      new_ent.typ     = rs_if.disp_type;
      new_ent.info    = rs_if.disp_additional_info;
      new_ent.rob     = rs_if.disp_rob_entry;
      new_ent.rs1_rdy = rs_if.disp_rs1_rdy;
      new_ent.rs1_val = rs_if.disp_rs1_val;
      new_ent.rs1_tag = rs_if.disp_rs1_tag;
      new_ent.rs2_rdy = rs_if.disp_rs2_rdy;
      new_ent.rs2_val = rs_if.disp_rs2_val;
      new_ent.rs2_tag = rs_if.disp_rs2_tag;
`ifdef ARITH_RS_CDB_BYPASS_EN
      new_ent = wake(new_ent, rs_if.cdb_valid, rs_if.cdb_rob_entry, rs_if.cdb_value);
`endif
   end

   always_comb begin
      for (int i = 0; i < RS_ENTRIES; i++) begin
         woke[i] = wake(ent_q[i], rs_if.cdb_valid, rs_if.cdb_rob_entry, rs_if.cdb_value);
      end
      woke[RS_ENTRIES] = '0;

      // After an issue the first free slot is one lower, hence count-1.
      wr_idx = sel_found ? (count_q - CW'(1)) : count_q;
      for (int i = 0; i < RS_ENTRIES; i++) begin
         if (sel_found && (CW'(i) >= sel_idx)) begin
            ent_d[i] = woke[i+1];
         end else begin
            ent_d[i] = woke[i];
         end
         if (disp_fire && (wr_idx == CW'(i))) begin
            ent_d[i] = new_ent;
         end
      end
      count_d = count_q + CW'(disp_fire) - CW'(sel_found);

      issue_valid_d = sel_found;
      issue_type_d  = issue_type_q;
      issue_info_d  = issue_info_q;
      issue_rob_d   = issue_rob_q;
      issue_rs1_d   = issue_rs1_q;
      issue_rs2_d   = issue_rs2_q;
      if (sel_found) begin
         issue_type_d = sel_ent.typ;
         issue_info_d = sel_ent.info;
         issue_rob_d  = sel_ent.rob;
         issue_rs1_d  = sel_ent.rs1_val;
         issue_rs2_d  = sel_ent.rs2_val;
      end

      if (rs_if.flush) begin
         for (int i = 0; i < RS_ENTRIES; i++) begin
            ent_d[i] = '0;
         end
         count_d       = '0;
         issue_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < RS_ENTRIES; i++) begin
            ent_q[i] <= '0;
         end
         count_q       <= '0;
         issue_valid_q <= 1'b0;
         issue_type_q  <= '0;
         issue_info_q  <= 1'b0;
         issue_rob_q   <= '0;
         issue_rs1_q   <= '0;
         issue_rs2_q   <= '0;
      end else begin
         for (int i = 0; i < RS_ENTRIES; i++) begin
            ent_q[i] <= ent_d[i];
         end
         count_q       <= count_d;
         issue_valid_q <= issue_valid_d;
         issue_type_q  <= issue_type_d;
         issue_info_q  <= issue_info_d;
         issue_rob_q   <= issue_rob_d;
         issue_rs1_q   <= issue_rs1_d;
         issue_rs2_q   <= issue_rs2_d;
      end
   end

   assign rs_if.disp_ready            = disp_ready;
   assign rs_if.issue_valid           = issue_valid_q;
   assign rs_if.issue_type            = issue_type_q;
   assign rs_if.issue_additional_info = issue_info_q;
   assign rs_if.issue_rob_entry       = issue_rob_q;
   assign rs_if.issue_rs1             = issue_rs1_q;
   assign rs_if.issue_rs2             = issue_rs2_q;
   assign rs_if.occupancy             = count_q;
endmodule

// File: tb/tb_arith_rs_scheduler.sv
// Directed bench for arith_rs_scheduler: dispatch/issue ordering, CDB wakeup, full, flush and reset.
module tb_arith_rs_scheduler;
   localparam int XLEN       = 32;
   localparam int ROB_SIZE   = 256;
   localparam int RS_ENTRIES = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   arith_rs_if #(.XLEN(XLEN), .ROB_SIZE(ROB_SIZE), .RS_ENTRIES(RS_ENTRIES)) rs_if ();

   arith_rs_scheduler #(.XLEN(XLEN), .ROB_SIZE(ROB_SIZE), .RS_ENTRIES(RS_ENTRIES)) dut (
      .clk   (clk),
      .rst   (rst),
      .rs_if (rs_if.slave)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rs_if.flush                = 1'b0;
      rs_if.disp_valid           = 1'b0;
      rs_if.disp_rob_entry       = '0;
      rs_if.disp_type            = '0;
      rs_if.disp_additional_info = 1'b0;
      rs_if.disp_rs1_rdy         = 1'b0;
      rs_if.disp_rs1_val         = '0;
      rs_if.disp_rs1_tag         = '0;
      rs_if.disp_rs2_rdy         = 1'b0;
      rs_if.disp_rs2_val         = '0;
      rs_if.disp_rs2_tag         = '0;
      rs_if.cdb_valid            = 1'b0;
      rs_if.cdb_rob_entry        = '0;
      rs_if.cdb_value            = '0;
   endtask

   task automatic disp(input logic [7:0] tag, input logic [2:0] typ, input logic info,
                       input logic r1, input logic [31:0] v1, input logic [7:0] t1,
                       input logic r2, input logic [31:0] v2, input logic [7:0] t2);
      rs_if.disp_valid           = 1'b1;
      rs_if.disp_rob_entry       = tag;
      rs_if.disp_type            = typ;
      rs_if.disp_additional_info = info;
      rs_if.disp_rs1_rdy         = r1;
      rs_if.disp_rs1_val         = v1;
      rs_if.disp_rs1_tag         = t1;
      rs_if.disp_rs2_rdy         = r2;
      rs_if.disp_rs2_val         = v2;
      rs_if.disp_rs2_tag         = t2;
   endtask

   task automatic cdb(input logic [7:0] tag, input logic [31:0] val);
      rs_if.cdb_valid     = 1'b1;
      rs_if.cdb_rob_entry = tag;
      rs_if.cdb_value     = val;
   endtask

   task automatic chk_issue(input string tag, input logic [7:0] rob,
                            input logic [31:0] rs1, input logic [31:0] rs2);
      check({tag, "_vld"}, rs_if.issue_valid, 1);
      check({tag, "_rob"}, rs_if.issue_rob_entry, rob);
      check({tag, "_rs1"}, rs_if.issue_rs1, rs1);
      check({tag, "_rs2"}, rs_if.issue_rs2, rs2);
   endtask

   initial begin
      idle();
      rst = 1'b1;
      tick();
      tick();
      check("rst_vld", rs_if.issue_valid, 0);
      check("rst_type", rs_if.issue_type, 0);
      check("rst_info", rs_if.issue_additional_info, 0);
      check("rst_rob", rs_if.issue_rob_entry, 0);
      check("rst_rs1", rs_if.issue_rs1, 0);
      check("rst_rs2", rs_if.issue_rs2, 0);
      check("rst_occ", rs_if.occupancy, 0);
      check("rst_rdy", rs_if.disp_ready, 0);
      rst = 1'b0;
      tick();

      // Single ready op: held after E, issued after E+1.
      disp(8'd5, 3'b000, 1'b1, 1'b1, 32'd10, 8'd0, 1'b1, 32'd3, 8'd0);
      #1 check("t1_rdy", rs_if.disp_ready, 1);
      tick();
      idle();
      check("t1_occ_held", rs_if.occupancy, 1);
      check("t1_early", rs_if.issue_valid, 0);
      tick();
      chk_issue("t1", 8'd5, 32'd10, 32'd3);
      check("t1_info", rs_if.issue_additional_info, 1);
      check("t1_occ_done", rs_if.occupancy, 0);
      tick();
      check("t1_empty_vld", rs_if.issue_valid, 0);
      check("t1_empty_hold", rs_if.issue_rob_entry, 5);

      // Younger ready op overtakes older waiting one; CDB wakes the older.
      disp(8'd7, 3'b000, 1'b0, 1'b1, 32'd1, 8'd0, 1'b0, 32'd0, 8'd9);
      tick();
      disp(8'd8, 3'b111, 1'b0, 1'b1, 32'd4, 8'd0, 1'b1, 32'd6, 8'd0);
      tick();
      idle();
      check("t2_occ2", rs_if.occupancy, 2);
      check("t2_none", rs_if.issue_valid, 0);
      tick();
      chk_issue("t2_tag8", 8'd8, 32'd4, 32'd6);
      check("t2_type7", rs_if.issue_type, 7);
      cdb(8'd9, 32'h20);
      tick();
      idle();
      check("t2_wake_vld", rs_if.issue_valid, 0);
      check("t2_occ1", rs_if.occupancy, 1);
      tick();
      chk_issue("t2_tag7", 8'd7, 32'd1, 32'h20);
      check("t2_occ0", rs_if.occupancy, 0);

      // Fill with waiting ops; entry 3 shares producer with entry 1.
      disp(8'd20, 3'b010, 1'b0, 1'b0, 32'd0, 8'd40, 1'b1, 32'd0, 8'd0);
      tick();
      disp(8'd21, 3'b010, 1'b0, 1'b0, 32'd0, 8'd41, 1'b1, 32'd1, 8'd0);
      tick();
      disp(8'd22, 3'b010, 1'b0, 1'b0, 32'd0, 8'd42, 1'b1, 32'd2, 8'd0);
      tick();
      disp(8'd23, 3'b010, 1'b0, 1'b0, 32'd0, 8'd41, 1'b1, 32'd3, 8'd0);
      tick();
      idle();
      #1;
      check("t3_full_occ", rs_if.occupancy, 4);
      check("t3_full_rdy", rs_if.disp_ready, 0);
      cdb(8'd42, 32'h55);
      tick();
      idle();
      #1;
      check("t3_still_full", rs_if.disp_ready, 0);
      tick();
      chk_issue("t3_e2", 8'd22, 32'h55, 32'd2);
      check("t3_occ3", rs_if.occupancy, 3);
      check("t3_rdy_back", rs_if.disp_ready, 1);
      cdb(8'd41, 32'h66);
      tick();
      idle();
      check("t3_gap", rs_if.issue_valid, 0);
      tick();
      chk_issue("t3_e1", 8'd21, 32'h66, 32'd1);
      tick();
      chk_issue("t3_e3", 8'd23, 32'h66, 32'd3);
      check("t3_occ1", rs_if.occupancy, 1);
      cdb(8'd40, 32'h77);
      tick();
      idle();
      tick();
      chk_issue("t3_e0", 8'd20, 32'h77, 32'd0);
      check("t3_occ0", rs_if.occupancy, 0);

      // Dispatch racing a broadcast of its own source tag.
      disp(8'd30, 3'b011, 1'b0, 1'b0, 32'd0, 8'd50, 1'b1, 32'd2, 8'd0);
      cdb(8'd50, 32'h99);
`ifdef ARITH_RS_CDB_BYPASS_EN
      #1 check("t4_rdy", rs_if.disp_ready, 1);
      tick();
      idle();
      check("t4_occ", rs_if.occupancy, 1);
`else
      #1 check("t4_rdy", rs_if.disp_ready, 0);
      tick();
      idle();
      check("t4_dropped", rs_if.occupancy, 0);
      disp(8'd30, 3'b011, 1'b0, 1'b1, 32'h99, 8'd0, 1'b1, 32'd2, 8'd0);
      tick();
      idle();
      check("t4_retry_occ", rs_if.occupancy, 1);
`endif
      tick();
      chk_issue("t4", 8'd30, 32'h99, 32'd2);
      check("t4_type", rs_if.issue_type, 3);
      tick();

      // Flush with an issue pending and a dispatch offered.
      disp(8'd61, 3'b000, 1'b0, 1'b0, 32'd0, 8'd70, 1'b1, 32'd0, 8'd0);
      tick();
      disp(8'd62, 3'b000, 1'b0, 1'b0, 32'd0, 8'd70, 1'b1, 32'd0, 8'd0);
      tick();
      disp(8'd63, 3'b000, 1'b0, 1'b1, 32'd1, 8'd0, 1'b1, 32'd1, 8'd0);
      tick();
      check("t5_occ3", rs_if.occupancy, 3);
      disp(8'd64, 3'b000, 1'b0, 1'b1, 32'd2, 8'd0, 1'b1, 32'd2, 8'd0);
      rs_if.flush = 1'b1;
      tick();
      idle();
      check("t5_flush_vld", rs_if.issue_valid, 0);
      check("t5_flush_occ", rs_if.occupancy, 0);
      tick();
      check("t5_after_vld", rs_if.issue_valid, 0);
      check("t5_after_occ", rs_if.occupancy, 0);

      // Reset mid-stream.
      disp(8'd80, 3'b011, 1'b1, 1'b1, 32'h11, 8'd0, 1'b1, 32'h22, 8'd0);
      tick();
      disp(8'd81, 3'b010, 1'b0, 1'b1, 32'h33, 8'd0, 1'b1, 32'h44, 8'd0);
      tick();
      chk_issue("t6_pre", 8'd80, 32'h11, 32'h22);
      check("t6_pre_type", rs_if.issue_type, 3);
      rst = 1'b1;
      disp(8'd82, 3'b000, 1'b0, 1'b1, 32'd5, 8'd0, 1'b1, 32'd5, 8'd0);
      #1 check("t6_rdy_in_rst", rs_if.disp_ready, 0);
      tick();
      check("t6_vld", rs_if.issue_valid, 0);
      check("t6_type", rs_if.issue_type, 0);
      check("t6_info", rs_if.issue_additional_info, 0);
      check("t6_rob", rs_if.issue_rob_entry, 0);
      check("t6_rs1", rs_if.issue_rs1, 0);
      check("t6_rs2", rs_if.issue_rs2, 0);
      check("t6_occ", rs_if.occupancy, 0);
      check("t6_rdy_hold", rs_if.disp_ready, 0);
      rst = 1'b0;
      idle();
      tick();
      check("t6_post_vld", rs_if.issue_valid, 0);
      check("t6_post_occ", rs_if.occupancy, 0);
      check("t6_post_rdy", rs_if.disp_ready, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
